// File: rtl/ghist_ftq_ctrl.sv
// Speculative global-history controller for the frontend FTQ.
// Holds the live speculative branch history, snapshots the pre-update history
// into the external snapshot memory on every enqueue, and on a redirect reads
// the snapshot back to rebuild history, enqueue pointer and occupancy.
module ghist_ftq_ctrl #(
    parameter int ENTRIES = 40,
    parameter int HIST_W  = 5,
    parameter int PTR_W   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic              enq_taken,
    output logic              enq_ready,
    output logic [PTR_W-1:0]  enq_idx,
    input  logic              deq_valid,
    input  logic              redirect_valid,
    input  logic [PTR_W-1:0]  redirect_idx,
    input  logic              redirect_taken,
    output logic [HIST_W-1:0] hist_out,
    output logic [PTR_W-1:0]  count,
    output logic              restoring,
    output logic              mem_w_en,
    output logic [PTR_W-1:0]  mem_w_addr,
    output logic [HIST_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [PTR_W-1:0]  mem_r_addr,
    input  logic [HIST_W-1:0] mem_r_data
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    // Pointer increment that wraps at the last slot rather than at 2^PTR_W.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(ENTRIES - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    state_t            state_r, state_n;
    logic [HIST_W-1:0] hist_r, hist_n;
    logic [PTR_W-1:0]  enq_ptr_r, enq_ptr_n;
    logic [PTR_W-1:0]  deq_ptr_r, deq_ptr_n;
    logic [PTR_W-1:0]  count_r, count_n;
    logic [PTR_W-1:0]  lat_idx_r, lat_idx_n;
    logic              lat_taken_r, lat_taken_n;

    logic              enq_ready_s;
    logic              enq_fire_s;
    logic              deq_fire_s;
    logic [PTR_W-1:0]  span_s;

    // Handshake qualification: enqueue only when not full, idle and no redirect.
    always_comb begin
        enq_ready_s = (count_r != PTR_W'(ENTRIES)) && (state_r == IDLE) && !redirect_valid;
        enq_fire_s  = enq_valid && enq_ready_s;
        deq_fire_s  = deq_valid && (count_r != {PTR_W{1'b0}});
    end

    // Distance from the post-dequeue head to the latched redirect slot, modulo ENTRIES.
    always_comb begin
        span_s = lat_idx_r - deq_ptr_n;
        if (lat_idx_r < deq_ptr_n) begin
            span_s = lat_idx_r - deq_ptr_n + PTR_W'(ENTRIES);
        end else begin
            span_s = lat_idx_r - deq_ptr_n;
        end
    end

    // Next-state logic: redirect latch, one-cycle restore, or normal enqueue/dequeue.
    always_comb begin
        state_n     = state_r;
        hist_n      = hist_r;
        enq_ptr_n   = enq_ptr_r;
        count_n     = count_r;
        lat_idx_n   = lat_idx_r;
        lat_taken_n = lat_taken_r;

        if (deq_fire_s) begin
            deq_ptr_n = wrap_inc(deq_ptr_r);
        end else begin
            deq_ptr_n = deq_ptr_r;
        end

        if (redirect_valid) begin
            // A newer redirect always wins, including one arriving mid-restore.
            state_n     = RESTORE;
            lat_idx_n   = redirect_idx;
            lat_taken_n = redirect_taken;
            if (deq_fire_s) begin
                count_n = count_r - PTR_W'(1);
            end else begin
                count_n = count_r;
            end
        end else if (state_r == RESTORE) begin
            // Snapshot is pre-update history of the redirected packet; append its resolved direction.
            hist_n    = HIST_W'({mem_r_data, lat_taken_r});
            enq_ptr_n = wrap_inc(lat_idx_r);
            count_n   = span_s + PTR_W'(1);
            state_n   = IDLE;
        end else begin
            if (enq_fire_s) begin
                hist_n    = HIST_W'({hist_r, enq_taken});
                enq_ptr_n = wrap_inc(enq_ptr_r);
            end else begin
                hist_n    = hist_r;
                enq_ptr_n = enq_ptr_r;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_n = count_r + PTR_W'(1);
                2'b01:   count_n = count_r - PTR_W'(1);
                default: count_n = count_r;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            hist_r      <= {HIST_W{1'b0}};
            enq_ptr_r   <= {PTR_W{1'b0}};
            deq_ptr_r   <= {PTR_W{1'b0}};
            count_r     <= {PTR_W{1'b0}};
            lat_idx_r   <= {PTR_W{1'b0}};
            lat_taken_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            hist_r      <= hist_n;
            enq_ptr_r   <= enq_ptr_n;
            deq_ptr_r   <= deq_ptr_n;
            count_r     <= count_n;
            lat_idx_r   <= lat_idx_n;
            lat_taken_r <= lat_taken_n;
        end
    end

    // Output mapping; memory ports are same-cycle with the accepted request.
    always_comb begin
        enq_ready  = enq_ready_s;
        enq_idx    = enq_ptr_r;
        hist_out   = hist_r;
        count      = count_r;
        restoring  = (state_r == RESTORE);
        mem_w_en   = enq_fire_s;
        mem_w_addr = enq_ptr_r;
        mem_w_data = hist_r;
        mem_r_en   = redirect_valid;
        mem_r_addr = redirect_idx;
    end

endmodule

// File: doc/ghist_ftq_ctrl.md
Name: ghist_ftq_ctrl

Overview:
- Speculative global-history controller that sits directly upstream of the 40x5 ghist snapshot memory in the frontend FTQ.
- Keeps the live speculative branch history register.
- On each fetch-packet enqueue, writes the pre-update history snapshot into the memory at the enqueue pointer.
- On a backend redirect, reads the snapshot back and restores history and pointers. Commits retire entries.

Parameters:
- ENTRIES, 40, number of snapshot slots; must match the memory depth.
- HIST_W, 5, history width; must match the memory data width.
- PTR_W, 6, width of pointers and memory addresses; must satisfy 2^PTR_W >= ENTRIES.

Ports:
- clock  in  1  single clock for all state; also drives the memory's R0_clk/W0_clk.
- reset  in  1  asynchronous, active-low reset.
- enq_valid  in  1  fetch packet enqueue request.
- enq_taken  in  1  packet ends in a predicted-taken branch.
- enq_ready  out  1  enqueue accepted this cycle when enq_valid && enq_ready.
- enq_idx  out  PTR_W  slot index assigned to the current enqueue (equals enq_ptr).
- deq_valid  in  1  commit of the oldest entry.
- redirect_valid  in  1  misprediction redirect.
- redirect_idx  in  PTR_W  slot of the mispredicted packet.
- redirect_taken  in  1  resolved direction of the mispredicted packet.
- hist_out  out  HIST_W  current speculative history (registered).
- count  out  PTR_W  occupied entries, 0..ENTRIES.
- restoring  out  1  high while state is RESTORE.
- mem_w_en  out  1  write enable to memory W0_en.
- mem_w_addr  out  PTR_W  write address to memory W0_addr.
- mem_w_data  out  HIST_W  write data to memory W0_data.
- mem_r_en  out  1  read enable to memory R0_en.
- mem_r_addr  out  PTR_W  read address to memory R0_addr.
- mem_r_data  in  HIST_W  read data from memory R0_data; valid one cycle after mem_r_en.

Behaviour:
- Reset (reset low, asynchronous): hist=0, enq_ptr=0, deq_ptr=0, count=0, state=IDLE. All outputs are therefore 0, except enq_ready=1 once reset deasserts and redirect_valid is low.
- enq_ready = (count != ENTRIES) && state==IDLE && !redirect_valid.
- Enqueue fire, same cycle, combinational:
  - mem_w_en=1, mem_w_addr=enq_ptr, mem_w_data=hist (pre-update snapshot).
- Enqueue fire, next edge:
  - hist <= {hist[HIST_W-2:0], enq_taken}.
  - enq_ptr <= enq_ptr+1, wrapping ENTRIES-1 -> 0.
  - count += 1.
- Dequeue:
  - If deq_valid && count!=0, deq_ptr advances with wrap and count -= 1.
  - deq_valid with count==0 is ignored.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Redirect accept, in IDLE or RESTORE:
  - Same cycle: mem_r_en=1, mem_r_addr=redirect_idx.
  - Latch redirect_idx and redirect_taken; state <= RESTORE.
  - Any enqueue in this cycle is blocked by enq_ready=0.
- RESTORE, one cycle when no new redirect arrives:
  - hist <= {mem_r_data[HIST_W-2:0], latched_taken}.
  - enq_ptr <= latched_idx+1, with wrap.
  - count <= ((latched_idx - deq_ptr') mod ENTRIES) + 1, where deq_ptr' is deq_ptr after any same-cycle dequeue.
  - state <= IDLE.
  - enq_ready=0; restoring=1.
- Redirect arriving while in RESTORE supersedes the pending one: new read issued, new values latched, state stays RESTORE.
- Dequeue during RESTORE is honoured.
- Redirect latency: hist_out reflects the restored value 2 edges after redirect_valid is sampled. enq_ready returns high the cycle after that restore edge.
- redirect_idx must lie within the occupied window [deq_ptr, enq_ptr). Otherwise behaviour is undefined; the bench flags it with an assertion.
- mem_r_en=0 whenever no redirect is accepted. mem_w_en=0 whenever no enqueue fires.
- Full state: count==ENTRIES with enq_ptr==deq_ptr. Empty state: count==0 with the pointers equal. count disambiguates the two.

Test Plan:
- Reset, then 3 enqueues with taken=1,0,1 from hist=0:
  - memory writes {0:00000, 1:00001, 2:00010}.
  - hist_out=00101, count=3, enq_idx=3.
- 40 enqueues with no dequeue:
  - enq_ready drops after the 40th; count=40.
  - A 41st enq_valid causes no write; enq_ptr wraps to 0.
- Full queue, then same-cycle enq_valid+deq_valid:
  - Enqueue blocked (ready=0); the dequeue is accepted; count=39.
  - The next cycle, enqueue is accepted at slot 0.
- After 5 enqueues (snapshot at slot 2 = 00010), redirect idx=2, taken=0:
  - mem_r_en pulse at addr 2; restoring high for 1 cycle.
  - hist_out=00100, enq_ptr=3, count=3; enq_ready high 2 cycles after the redirect.
- Back-to-back redirects idx=4 then idx=1:
  - Final state comes from slot 1; count=2; only one restore edge commits.
- Reset asserted mid-RESTORE:
  - All state clears asynchronously; restoring=0, count=0, hist_out=0.
